// File: rtl/servo_pkg.sv
// servo_pkg: servo timing constants shared with the PWM generator, plus the decoder FSM states.
package servo_pkg;
  localparam int MIN_CLKS     = 25000;
  localparam int MAX_CLKS     = 50000;
  localparam int PERIOD_CLKS  = 500000;
  localparam int RANGE_CLKS   = MAX_CLKS - MIN_CLKS;
  localparam int TOL_CLKS     = 2500;
  localparam int TIMEOUT_CLKS = 1250000;
  localparam int FILTER_LEN   = 8;
  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, HIGH} dec_state_t;
endpackage

// File: rtl/servo_pwm_decoder_if.sv
// servo_pwm_decoder_if: servo input pin and decoded position/status bundle.
//   master: decoder side (drives position, strobes, status). slave: pin driver / consumer side.
interface servo_pwm_decoder_if;
  logic        pwm_in;
  logic [15:0] position;
  logic        pos_valid;
  logic        pulse_err;
  logic        signal_lost;
  logic        led;
  modport master (input pwm_in, output position, pos_valid, pulse_err, signal_lost, led);
  modport slave (output pwm_in, input position, pos_valid, pulse_err, signal_lost, led);
endinterface

// File: rtl/servo_in_cond.sv
// servo_in_cond: synchronizes the servo pin, optionally glitch-filters it, and registers edge pulses.
//   clk, rst   : board clock, async active-high reset
//   i_pwm      : asynchronous pin
//   o_level    : conditioned level
//   o_rise/fall: one-cycle edge pulses of o_level
//   Macro SERVO_DEC_GLITCH_FILTER_EN enables the FILTER_LEN-sample filter.
module servo_in_cond #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
`ifdef SERVO_DEC_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  localparam int FL = FILT_EN ? FILTER_LEN : 0;
  logic [1:0] r_sync;
  logic       w_lvl;
  logic       r_lvl;
  logic       r_rise;
  logic       r_fall;
  // Reset to high so a pulse in progress across reset never produces a false low/rise.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], i_pwm};
  if (FL > 0) begin : g_filt
    localparam int CW = $clog2(FL + 1);
    logic [CW-1:0] r_cnt;
    logic          r_filt;
    // Counts consecutive samples disagreeing with the filtered value; any agreement restarts it.
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_filt <= 1'b1;
        r_cnt  <= '0;
      end else if (r_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FL - 1)) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    assign w_lvl = r_filt;
  end else begin : g_pass
    assign w_lvl = r_sync[1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_lvl  <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_lvl  <= w_lvl;
      r_rise <= w_lvl & ~r_lvl;
      r_fall <= ~w_lvl & r_lvl;
    end
  assign o_level = r_lvl;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures servo pulse high time and converts it to a 0..(MAX-MIN) position code.
//   clk, rst : board clock, async active-high reset
//   dec      : servo_pwm_decoder_if.master (pwm_in, position, pos_valid, pulse_err, signal_lost, led)
//   Macro SERVO_DEC_GLITCH_FILTER_EN enables the input glitch filter.
module servo_pwm_decoder #(
  parameter int MIN_CLKS     = servo_pkg::MIN_CLKS,
  parameter int MAX_CLKS     = servo_pkg::MAX_CLKS,
  parameter int TOL_CLKS     = servo_pkg::TOL_CLKS,
  parameter int TIMEOUT_CLKS = servo_pkg::TIMEOUT_CLKS,
  parameter int FILTER_LEN   = servo_pkg::FILTER_LEN
) (
  input logic                 clk,
  input logic                 rst,
  servo_pwm_decoder_if.master dec
);
  import servo_pkg::*;
  localparam logic [16:0] LO_W  = 17'(MIN_CLKS - TOL_CLKS);
  localparam logic [16:0] HI_W  = 17'(MAX_CLKS + TOL_CLKS);
  localparam logic [16:0] MIN_W = 17'(MIN_CLKS);
  localparam logic [16:0] MAX_W = 17'(MAX_CLKS);
  localparam logic [20:0] TO_W  = 21'(TIMEOUT_CLKS);
  dec_state_t  r_state;
  dec_state_t  w_state;
  logic        w_level;
  logic        w_rise;
  logic        w_fall;
  logic [16:0] r_width;
  logic [16:0] w_meas;
  logic [16:0] w_span;
  logic [20:0] r_to;
  logic [20:0] w_to;
  logic [15:0] r_pos;
  logic [15:0] w_pos;
  logic        r_valid;
  logic        w_valid;
  logic        r_err;
  logic        w_err;
  logic        r_lost;
  logic        w_lost;
  logic        r_led;
  servo_in_cond #(.FILTER_LEN(FILTER_LEN)) u_in (
    .clk    (clk),
    .rst    (rst),
    .i_pwm  (dec.pwm_in),
    .o_level(w_level),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= WAIT_LOW;
    else r_state <= w_state;
  // r_width lags the level by one cycle, so the fall cycle itself is added to get the true width.
  always_comb begin
    w_meas  = &r_width ? r_width : r_width + 17'd1;
    w_span  = w_meas < MIN_W ? '0 : w_meas > MAX_W ? MAX_W - MIN_W : w_meas - MIN_W;
    w_state = r_state;
    w_valid = 1'b0;
    w_err   = 1'b0;
    w_pos   = r_pos;
    case (r_state)
      WAIT_LOW:  w_state = w_level ? WAIT_LOW : WAIT_RISE;
      WAIT_RISE: w_state = w_rise ? HIGH : WAIT_RISE;
      HIGH:
        if (r_width > HI_W) begin
          w_err   = 1'b1;
          w_state = WAIT_LOW;
        end else if (w_fall) begin
          w_state = WAIT_RISE;
          w_err   = w_meas < LO_W || w_meas > HI_W;
          w_valid = !w_err;
          w_pos   = w_err ? r_pos : 16'(w_span);
        end
      default: w_state = WAIT_LOW;
    endcase
    w_to   = w_rise ? '0 : r_to >= TO_W ? TO_W : r_to + 21'd1;
    w_lost = w_valid ? 1'b0 : (w_to == TO_W && r_to != TO_W) ? 1'b1 : r_lost;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_width <= '0;
      r_to    <= '0;
      r_pos   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_lost  <= 1'b1;
      r_led   <= 1'b0;
    end else begin
      r_width <= w_rise ? '0 : (r_state == HIGH && !(&r_width)) ? r_width + 17'd1 : r_width;
      r_to    <= w_to;
      r_pos   <= w_pos;
      r_valid <= w_valid;
      r_err   <= w_err;
      r_lost  <= w_lost;
      r_led   <= ~w_lost;
    end
  assign dec.position    = r_pos;
  assign dec.pos_valid   = r_valid;
  assign dec.pulse_err   = r_err;
  assign dec.signal_lost = r_lost;
  assign dec.led         = r_led;
endmodule
